// File: rtl/core_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK/HALT.
// Ports: clock, reset_n (async low); memory_* bus (request held until ready);
//   instruction out to an external decoder, decoded_* and alu_result back in;
//   program_counter, register_write_strobe, load_data, retired_count, halted.
// Option: define TRAP_ON_INVALID_EN to halt on decoded_invalid (else NOP).
module core_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        memory_request,
  output logic        memory_write,
  output logic [31:0] memory_address,
  input  logic        memory_ready,
  input  logic [31:0] memory_read_data,
  output logic [31:0] instruction,
  input  logic        decoded_register_write_enable,
  input  logic        decoded_memory_write_enable,
  input  logic        decoded_load,
  input  logic        decoded_branch,
  input  logic        decoded_jump,
  input  logic        decoded_invalid,
  input  logic [31:0] alu_result,
  output logic [31:0] program_counter,
  output logic        register_write_strobe,
  output logic [31:0] load_data,
  output logic [31:0] retired_count,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEMORY,
    S_WRITEBACK,
    S_HALT
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_load_data;
  logic [31:0] r_retired;
  // Set when the instruction in flight is being retired as a NOP.
  logic        r_nop;
  logic        r_halted;

  logic        w_fetch;
  logic        w_mem;
  logic        w_wb;
  logic        w_mem_op;
  logic        w_redirect;
  logic [31:0] w_next_pc;

  assign w_fetch    = (r_state == S_FETCH);
  assign w_mem      = (r_state == S_MEMORY);
  assign w_wb       = (r_state == S_WRITEBACK);
  assign w_mem_op   = decoded_load | decoded_memory_write_enable;
  assign w_redirect = (decoded_jump | decoded_branch) & ~r_nop;
  assign w_next_pc  = w_redirect ? {alu_result[31:2], 2'b00}
                                 : r_pc + 32'd4;

  // Gated by reset_n so a reset mid-transaction drops the request at once,
  // and the reset FETCH state presents RESET_VECTOR as soon as it releases.
  assign memory_request = reset_n & (w_fetch | w_mem);
  assign memory_write   = reset_n & w_mem & decoded_memory_write_enable;
  assign memory_address = w_mem ? alu_result : r_pc;

  assign register_write_strobe =
    w_wb & decoded_register_write_enable & ~r_nop;

  assign instruction     = r_instr;
  assign program_counter = r_pc;
  assign load_data       = r_load_data;
  assign retired_count   = r_retired;
  assign halted          = r_halted;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_FETCH;
      r_pc        <= RESET_VECTOR;
      r_instr     <= 32'd0;
      r_load_data <= 32'd0;
      r_retired   <= 32'd0;
      r_nop       <= 1'b0;
      r_halted    <= 1'b0;
    end else begin
      unique case (r_state)
        S_FETCH: begin
          if (memory_ready) begin
            r_instr <= memory_read_data;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          r_state <= S_EXECUTE;
        end
        S_EXECUTE: begin
`ifdef TRAP_ON_INVALID_EN
          if (decoded_invalid) begin
            r_halted <= 1'b1;
            r_state  <= S_HALT;
          end else if (w_mem_op) begin
            r_state <= S_MEMORY;
          end else begin
            r_state <= S_WRITEBACK;
          end
`else
          r_nop <= decoded_invalid;
          if (decoded_invalid) begin
            r_state <= S_WRITEBACK;
          end else if (w_mem_op) begin
            r_state <= S_MEMORY;
          end else begin
            r_state <= S_WRITEBACK;
          end
`endif
        end
        S_MEMORY: begin
          if (memory_ready) begin
            if (decoded_load) begin
              r_load_data <= memory_read_data;
            end
            r_state <= S_WRITEBACK;
          end
        end
        S_WRITEBACK: begin
          r_pc      <= w_next_pc;
          r_retired <= r_retired + 32'd1;
          r_nop     <= 1'b0;
          r_state   <= S_FETCH;
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: begin
          r_state <= S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboard bench for core_sequencer: directed instruction stream,
// bus and writeback events checked by a separate negedge monitor.
module tb_core_sequencer;

  localparam logic [31:0] RV = 32'h0000_0100;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        memory_request;
  logic        memory_write;
  logic [31:0] memory_address;
  logic        memory_ready = 1'b0;
  logic [31:0] memory_read_data = 32'd0;
  logic [31:0] instruction;
  logic        d_rwe = 1'b0;
  logic        d_mwe = 1'b0;
  logic        d_ld = 1'b0;
  logic        d_br = 1'b0;
  logic        d_jp = 1'b0;
  logic        d_inv = 1'b0;
  logic [31:0] alu_result = 32'd0;
  logic [31:0] program_counter;
  logic        register_write_strobe;
  logic [31:0] load_data;
  logic [31:0] retired_count;
  logic        halted;

  core_sequencer #(.RESET_VECTOR(RV)) dut (
    .clock                         (clock),
    .reset_n                       (reset_n),
    .memory_request                (memory_request),
    .memory_write                  (memory_write),
    .memory_address                (memory_address),
    .memory_ready                  (memory_ready),
    .memory_read_data              (memory_read_data),
    .instruction                   (instruction),
    .decoded_register_write_enable (d_rwe),
    .decoded_memory_write_enable   (d_mwe),
    .decoded_load                  (d_ld),
    .decoded_branch                (d_br),
    .decoded_jump                  (d_jp),
    .decoded_invalid               (d_inv),
    .alu_result                    (alu_result),
    .program_counter               (program_counter),
    .register_write_strobe         (register_write_strobe),
    .load_data                     (load_data),
    .retired_count                 (retired_count),
    .halted                        (halted)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
  } bus_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ret;
    logic [31:0] ld;
  } wb_t;

  bus_t q_bus[$];
  wb_t  q_wb[$];

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_pc  = RV;
  logic [31:0] exp_ret = 32'd0;
  logic [31:0] exp_ins = 32'd0;
  logic [31:0] exp_ld  = 32'd0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents an event.
  always @(negedge clock) begin
    if (reset_n) begin
      if (memory_request && memory_ready) begin
        if (q_bus.size() == 0) begin
          chk1("unexpected_bus_txn", 1'b1, 1'b0);
        end else begin
          bus_t b;
          b = q_bus.pop_front();
          chk("bus_addr", memory_address, b.addr);
          chk1("bus_write", memory_write, b.wr);
        end
      end
      if (register_write_strobe) begin
        if (q_wb.size() == 0) begin
          chk1("unexpected_strobe", 1'b1, 1'b0);
        end else begin
          wb_t w;
          w = q_wb.pop_front();
          chk("wb_pc", program_counter, w.pc);
          chk("wb_retired", retired_count, w.ret);
          chk("wb_load_data", load_data, w.ld);
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_req(output logic ok);
    int n = 0;
    while (!memory_request && n < 8) begin
      step();
      n++;
    end
    ok = memory_request;
    if (!ok) chk1("request_timeout", 1'b0, 1'b1);
  endtask

  task automatic run_instr(
    input logic [31:0] ins,
    input logic rwe, input logic mwe, input logic ld,
    input logic br, input logic jp, input logic inv,
    input logic [31:0] alu, input logic [31:0] rd,
    input int fstall, input int mstall
  );
    logic ok;
    logic memop;
    logic trap;
    bus_t b;
    wb_t  w;
`ifdef TRAP_ON_INVALID_EN
    trap = inv;
`else
    trap = 1'b0;
`endif
    memop = (ld | mwe) & ~inv;
    wait_req(ok);
    if (!ok) return;
    d_rwe = rwe; d_mwe = mwe; d_ld = ld;
    d_br = br; d_jp = jp; d_inv = inv;
    alu_result = alu;
    memory_read_data = ins;
    b.addr = exp_pc; b.wr = 1'b0;
    q_bus.push_back(b);
    for (int i = 0; i < fstall; i++) begin
      step();
      chk1("fstall_req", memory_request, 1'b1);
      chk("fstall_addr", memory_address, exp_pc);
      chk1("fstall_write", memory_write, 1'b0);
      chk("fstall_instr", instruction, exp_ins);
    end
    memory_ready = 1'b1;
    step();
    memory_ready = 1'b0;
    exp_ins = ins;
    chk("instr_loaded", instruction, ins);
    step();
    step();
    if (trap) begin
      for (int i = 0; i < 4; i++) begin
        chk1("halt_flag", halted, 1'b1);
        chk1("halt_no_req", memory_request, 1'b0);
        chk1("halt_no_strobe", register_write_strobe, 1'b0);
        chk("halt_pc", program_counter, exp_pc);
        chk("halt_retired", retired_count, exp_ret);
        step();
      end
      return;
    end
    if (memop) begin
      memory_read_data = rd;
      b.addr = alu; b.wr = mwe;
      q_bus.push_back(b);
      for (int i = 0; i < mstall; i++) begin
        chk1("mstall_req", memory_request, 1'b1);
        chk("mstall_addr", memory_address, alu);
        chk1("mstall_write", memory_write, mwe);
        step();
      end
      memory_ready = 1'b1;
      step();
      memory_ready = 1'b0;
      if (ld) exp_ld = rd;
      chk("load_data", load_data, exp_ld);
    end
    chk1("wb_strobe", register_write_strobe, rwe & ~inv);
    chk1("wb_no_write", memory_write, 1'b0);
    chk1("wb_no_req", memory_request, 1'b0);
    if (rwe && !inv) begin
      w.pc = exp_pc; w.ret = exp_ret; w.ld = exp_ld;
      q_wb.push_back(w);
    end
    if ((br | jp) && !inv) exp_pc = {alu[31:2], 2'b00};
    else exp_pc = exp_pc + 32'd4;
    exp_ret = exp_ret + 32'd1;
    step();
    chk("next_pc", program_counter, exp_pc);
    chk("retired", retired_count, exp_ret);
    chk1("no_strobe_after_wb", register_write_strobe, 1'b0);
    chk1("not_halted", halted, 1'b0);
  endtask

  initial begin
    logic ok;
    bus_t b;
    step();
    step();
    chk1("rst_req", memory_request, 1'b0);
    chk1("rst_strobe", register_write_strobe, 1'b0);
    chk("rst_pc", program_counter, RV);
    chk("rst_instr", instruction, 32'd0);
    chk("rst_load_data", load_data, 32'd0);
    chk("rst_retired", retired_count, 32'd0);
    chk1("rst_halted", halted, 1'b0);
    reset_n = 1'b1;
    #1;
    chk1("first_req", memory_request, 1'b1);
    chk("first_addr", memory_address, RV);

    // ADDI, back-to-back ready
    run_instr(32'h0010_0093, 1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0);
    // ADDI with three-cycle fetch stall
    run_instr(32'h0020_0113, 1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 3, 0);
    // LW from 0x2000
    run_instr(32'h0000_2183, 1, 0, 1, 0, 0, 0, 32'h2000,
              32'hDEAD_BEEF, 0, 0);
    // SW to 0x3000 with two-cycle memory stall
    run_instr(32'h0030_2023, 0, 1, 0, 0, 0, 0, 32'h3000,
              32'h0, 0, 2);
    // taken branch, target bits [1:0] cleared
    run_instr(32'h0000_0063, 0, 0, 0, 1, 0, 0, 32'h0000_0043,
              32'h0, 0, 0);
    // JAL to top of address space
    run_instr(32'h0000_006F, 1, 0, 0, 0, 1, 0, 32'hFFFF_FFFF,
              32'h0, 0, 0);
    // ADDI at 0xFFFFFFFC wraps PC to 0
    run_instr(32'h0010_0093, 1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0);

    // reset during a stalled MEMORY request
    wait_req(ok);
    d_rwe = 1; d_mwe = 0; d_ld = 1; d_br = 0; d_jp = 0; d_inv = 0;
    alu_result = 32'h2000;
    memory_read_data = 32'h0000_2183;
    b.addr = exp_pc; b.wr = 1'b0;
    q_bus.push_back(b);
    memory_ready = 1'b1;
    step();
    memory_ready = 1'b0;
    step();
    step();
    chk1("mem_wait_req", memory_request, 1'b1);
    chk("mem_wait_addr", memory_address, 32'h2000);
    #2;
    reset_n = 1'b0;
    #1;
    chk1("reset_drops_req", memory_request, 1'b0);
    chk("reset_pc", program_counter, RV);
    chk("reset_retired", retired_count, 32'd0);
    chk("reset_load_data", load_data, 32'd0);
    step();
    reset_n = 1'b1;
    #1;
    chk1("restart_req", memory_request, 1'b1);
    chk("restart_addr", memory_address, RV);
    exp_pc = RV; exp_ret = 32'd0; exp_ins = 32'd0; exp_ld = 32'd0;

    run_instr(32'h0010_0093, 1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0);
    // invalid instruction with write enable raised
    run_instr(32'hFFFF_FFFF, 1, 0, 0, 0, 1, 1, 32'h4000, 32'h0, 0, 0);
`ifndef TRAP_ON_INVALID_EN
    run_instr(32'h0010_0093, 1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0);
`endif
    step();
    chk("bus_queue_empty", q_bus.size(), 32'd0);
    chk("wb_queue_empty", q_wb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
